// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage request, flush/clear controls and the
// stall/issue/forwarding/counter results of the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int AW = 5,
    parameter int DEPTH = 3,
    parameter int CW = 16
);
    localparam int FW = $clog2(DEPTH);
    logic id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic id_use_rs;
    logic id_use_rt;
    logic id_wr_en;
    logic [AW-1:0] id_rd;
    logic id_is_load;
    logic flush;
    logic cnt_clr;
    logic stall;
    logic issue;
    logic [FW-1:0] fwd_a;
    logic [FW-1:0] fwd_b;
    logic [DEPTH-1:0] stage_valid;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_rd, id_is_load,
        output flush, cnt_clr,
        input stall, issue, fwd_a, fwd_b, stage_valid, stall_cnt, flush_cnt
    );

    modport slave (
        input id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_rd, id_is_load,
        input flush, cnt_clr,
        output stall, issue, fwd_a, fwd_b, stage_valid, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destinations, stalls on load-use hazards,
// selects EX operand forwarding sources and counts stall/flush events.
module hazard_scoreboard #(
    parameter int AW = 5,
    parameter int DEPTH = 3,
    parameter int LD_READY = 2,
    parameter int CW = 16
) (
    input logic clock,
    input logic reset,
    hazard_scoreboard_if.slave sb
);
    localparam int FW = $clog2(DEPTH);
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] is_load;
    logic [AW-1:0] rd [DEPTH];
    logic [AW-1:0] ex_rs;
    logic [AW-1:0] ex_rt;
    logic ex_use_rs;
    logic ex_use_rt;
    logic hz_rs;
    logic hz_rt;
    logic stall;
    logic issue;
    logic [FW-1:0] fa;
    logic [FW-1:0] fb;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    // Scanning oldest to youngest lets the youngest matching stage win.
    always_comb begin
        hz_rs = 1'b0;
        hz_rt = 1'b0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (valid[s] && rd[s] == sb.id_rs) hz_rs = is_load[s] && (s + 1 < LD_READY);
            if (valid[s] && rd[s] == sb.id_rt) hz_rt = is_load[s] && (s + 1 < LD_READY);
        end
    end

    assign stall = sb.id_valid && !sb.flush &&
                   ((hz_rs && sb.id_use_rs && sb.id_rs != '0) ||
                    (hz_rt && sb.id_use_rt && sb.id_rt != '0));
    assign issue = sb.id_valid && !stall && !sb.flush;

    always_comb begin
        fa = '0;
        fb = '0;
        for (int s = DEPTH - 1; s >= 1; s--) begin
            if (valid[s] && rd[s] == ex_rs) fa = FW'(s);
            if (valid[s] && rd[s] == ex_rt) fb = FW'(s);
        end
    end

    assign sb.stall = stall;
    assign sb.issue = issue;
    assign sb.fwd_a = (ex_use_rs && ex_rs != '0) ? fa : '0;
    assign sb.fwd_b = (ex_use_rt && ex_rt != '0) ? fb : '0;
    assign sb.stage_valid = valid;
    assign sb.stall_cnt = stall_cnt;
    assign sb.flush_cnt = flush_cnt;

    // Writes to r0 travel down the pipe but never become producers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
            is_load <= '0;
            for (int s = 0; s < DEPTH; s++) rd[s] <= '0;
            ex_rs <= '0;
            ex_rt <= '0;
            ex_use_rs <= 1'b0;
            ex_use_rt <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            valid <= {valid[DEPTH-2:0], issue && sb.id_wr_en && sb.id_rd != '0};
            is_load <= {is_load[DEPTH-2:0], issue && sb.id_is_load};
            for (int s = DEPTH - 1; s >= 1; s--) rd[s] <= rd[s-1];
            rd[0] <= issue ? sb.id_rd : '0;
            ex_rs <= issue ? sb.id_rs : '0;
            ex_rt <= issue ? sb.id_rt : '0;
            ex_use_rs <= issue && sb.id_use_rs;
            ex_use_rt <= issue && sb.id_use_rt;
            stall_cnt <= sb.cnt_clr ? '0 : stall_cnt + CW'(stall && !(&stall_cnt));
            flush_cnt <= sb.cnt_clr ? '0 : flush_cnt + CW'(sb.flush && !(&flush_cnt));
        end
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter DEPTH, default 3, tracked in-flight stages after decode (0=EX, 1=MEM, ..., DEPTH-1=WB); legal range DEPTH>=2.
REQ-003 Parameter LD_READY, default 2, first stage index at which load data is forwardable; legal range 1<=LD_READY<=DEPTH-1.
REQ-004 Parameter CW, default 16, performance-counter width.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clock  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high; clears all state.
REQ-008 id_valid  in  1  valid instruction in ID.
REQ-009 id_rs, id_rt  in  AW each  ID source registers.
REQ-010 id_use_rs, id_use_rt  in  1 each  source actually read.
REQ-011 id_wr_en  in  1  ID instruction writes a register.
REQ-012 id_rd  in  AW  ID destination register.
REQ-013 id_is_load  in  1  ID instruction is a load.
REQ-014 flush  in  1  taken branch/jump resolved in ID; discard ID instruction.
REQ-015 cnt_clr  in  1  synchronous clear of both counters.
REQ-016 stall  out  1  hold PC and IF/ID, insert bubble.
REQ-017 issue  out  1  ID instruction advances into EX this cycle.
REQ-018 fwd_a, fwd_b  out  FW=clog2(DEPTH) each  forward source for EX operands: 0 = register file, s = stage s result.
REQ-019 stage_valid  out  DEPTH  per-stage occupancy, bit s = stage s.
REQ-020 stall_cnt, flush_cnt  out  CW each  saturating event counters.

Function
REQ-021 Per stage s, the block SHALL hold valid[s], rd[s], is_load[s], and for stage 0 only, ex_rs/ex_rt/ex_use_rs/ex_use_rt.
REQ-022 The block SHALL treat an instruction as a producer only if id_wr_en=1 and id_rd!=0; a write to r0 SHALL enter the pipe with valid=0.
REQ-023 The block SHALL define, for source src in ID, the match as the youngest stage s (lowest index) with valid[s] && rd[s]==src; src=0 or use flag 0 SHALL never match.
REQ-024 The block SHALL raise hazard when the match exists, is_load[s]=1 and s+1<LD_READY; ALU producers SHALL never cause hazard.
REQ-025 stall SHALL equal id_valid && hazard(rs or rt) && !flush, combinationally from registered state and ID inputs.
REQ-026 issue SHALL equal id_valid && !stall && !flush.
REQ-027 On every rising edge, stages 1..DEPTH-1 SHALL shift from stages 0..DEPTH-2 unconditionally; stage DEPTH-1 contents retire.
REQ-028 On the same edge, stage 0 SHALL load the ID instruction when issue=1, otherwise a bubble (all fields 0).
REQ-029 fwd_a SHALL equal the youngest s in 1..DEPTH-1 with valid[s] && rd[s]==ex_rs && ex_use_rs && ex_rs!=0, else 0; fwd_b likewise with ex_rt.
REQ-030 A stall SHALL last exactly LD_READY-1-s cycles for a load matched at stage s; it SHALL NOT exceed LD_READY-1 cycles.
REQ-031 The register file SHALL return the written value when read in the same cycle as the WB write; the block SHALL take no action for a producer leaving stage DEPTH-1.
REQ-032 stall_cnt SHALL increment by 1 on each edge with stall=1; flush_cnt SHALL increment by 1 on each edge with flush=1; each SHALL saturate at 2^CW-1.
REQ-033 cnt_clr=1 SHALL zero both counters on the edge and take priority over increment.
REQ-034 flush and hazard in the same cycle SHALL give stall=0, issue=0, bubble into stage 0, and flush_cnt increment only.

Reset
REQ-035 On reset assertion, the block SHALL immediately clear all valid bits, fields and counters, including mid-stall.
REQ-036 During and after reset, the outputs SHALL be: stall=0, issue=id_valid&&!flush, fwd_a=fwd_b=0, stage_valid=0, stall_cnt=flush_cnt=0.

Verification (DEPTH=3, LD_READY=2)
REQ-037 lw r8 issued, next ID add r9,r8,r8 -> stall=1 for 1 cycle, stall_cnt=1, then issue=1; in EX, fwd_a=fwd_b=2.
REQ-038 add r8 issued, next ID sub r10,r8,r3 -> no stall; in EX, fwd_a=1, fwd_b=0.
REQ-039 r8 written by ALU ops in stages 1 and 2, consumer of r8 in EX -> fwd_a=1 (youngest wins).
REQ-040 lw r0 then add using r0 -> stall=0, fwd_a=0, stage_valid[0]=0 after issue.
REQ-041 load-use hazard with flush=1 same cycle -> stall=0, issue=0, bubble, flush_cnt=1, stall_cnt=0; stall_cnt preset to 0xFFFF plus another stall -> stays 0xFFFF.
REQ-042 reset asserted mid-stall, between clock edges -> stage_valid=0 and stall=0 before the next edge; counters=0.
